// File: rtl/cic_comb_variable.sv
// Decimating CIC comb chain that runs at the decimated rate, with a runtime output scaling shift.
// A shift load also flushes the pipeline, so every rate change starts from zeroed comb history.
module cic_comb_variable #(
  parameter int DATA_WIDTH_INP   = 32,
  parameter int DATA_WIDTH_OUT   = 16,
  parameter int STAGES           = 3,
  parameter int DIFF_DELAY       = 1,
  parameter int DATA_WIDTH_SHIFT = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_WIDTH_INP-1:0]   s_axis_in_tdata,
  input  logic                        s_axis_in_tvalid,
  input  logic [DATA_WIDTH_SHIFT-1:0] s_axis_shift_tdata,
  input  logic                        s_axis_shift_tvalid,
  output logic [DATA_WIDTH_OUT-1:0]   m_axis_out_tdata,
  output logic                        m_axis_out_tvalid
);

  localparam int                          SHIFT_MAX   = DATA_WIDTH_INP - DATA_WIDTH_OUT;
  localparam logic [31:0]                 SHIFT_MAX_U = 32'(SHIFT_MAX);
  localparam logic [DATA_WIDTH_SHIFT-1:0] SHIFT_MAX_W = DATA_WIDTH_SHIFT'(SHIFT_MAX);

  logic signed [DATA_WIDTH_INP-1:0] stage_r [STAGES];
  logic signed [DATA_WIDTH_INP-1:0] dly_r   [STAGES][DIFF_DELAY];
  logic        [STAGES-1:0]         valid_r;
  logic signed [DATA_WIDTH_INP-1:0] sec_in_s  [STAGES];
  logic                             sec_vld_s [STAGES];
  logic signed [DATA_WIDTH_INP-1:0] shifted_s;
  logic        [DATA_WIDTH_SHIFT-1:0] shift_r;
  logic        [DATA_WIDTH_SHIFT-1:0] shift_clamp_s;
  logic        [DATA_WIDTH_OUT-1:0]   out_data_r;
  logic                               out_valid_r;

  // Section inputs: section 0 takes the stream, later sections take the previous stage.
  always_comb begin
    sec_in_s[0]  = s_axis_in_tdata;
    sec_vld_s[0] = s_axis_in_tvalid;
    for (int k = 1; k < STAGES; k++) begin
      sec_in_s[k]  = stage_r[k-1];
      sec_vld_s[k] = valid_r[k-1];
    end
  end

  // Comb sections: each subtracts the sample DIFF_DELAY accepted inputs back, only on valid.
  always_ff @(posedge clk) begin
    if (reset || s_axis_shift_tvalid) begin
      valid_r <= '0;
      for (int k = 0; k < STAGES; k++) begin
        stage_r[k] <= '0;
        for (int j = 0; j < DIFF_DELAY; j++) begin
          dly_r[k][j] <= '0;
        end
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        valid_r[k] <= sec_vld_s[k];
        if (sec_vld_s[k]) begin
          stage_r[k]  <= sec_in_s[k] - dly_r[k][DIFF_DELAY-1];
          dly_r[k][0] <= sec_in_s[k];
          for (int j = 1; j < DIFF_DELAY; j++) begin
            dly_r[k][j] <= dly_r[k][j-1];
          end
        end
      end
    end
  end

  // Clamp the requested shift so the kept window never runs past the MSB.
  always_comb begin
    shift_clamp_s = s_axis_shift_tdata;
    if (32'(s_axis_shift_tdata) > SHIFT_MAX_U) begin
      shift_clamp_s = SHIFT_MAX_W;
    end else begin
      shift_clamp_s = s_axis_shift_tdata;
    end
  end

  // Arithmetic shift keeps the sign of the comb result before truncation.
  always_comb begin
    shifted_s = stage_r[STAGES-1] >>> shift_r;
  end

  // Output scaling register and shift control; data holds between valid pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_r     <= SHIFT_MAX_W;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
    end else if (s_axis_shift_tvalid) begin
      shift_r     <= shift_clamp_s;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= valid_r[STAGES-1];
      if (valid_r[STAGES-1]) begin
        out_data_r <= shifted_s[DATA_WIDTH_OUT-1:0];
      end
    end
  end

  assign m_axis_out_tdata  = out_data_r;
  assign m_axis_out_tvalid = out_valid_r;

endmodule

// File: tb/tb_cic_comb_variable.sv
// Scoreboard bench for cic_comb_variable: three configurations driven with directed vectors,
// expected samples and their arrival cycle queued at issue time, checked by a negedge monitor.
module tb_cic_comb_variable;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  bit   done = 1'b0;

  // Instance A: 32/32, 3 stages, M=1
  logic [31:0] a_in_d = '0;
  logic        a_in_v = 1'b0;
  logic [5:0]  a_sh_d = '0;
  logic        a_sh_v = 1'b0;
  logic [31:0] a_out_d;
  logic        a_out_v;
  // Instance B: 8/8, 1 stage
  logic [7:0]  b_in_d = '0;
  logic        b_in_v = 1'b0;
  logic [5:0]  b_sh_d = '0;
  logic        b_sh_v = 1'b0;
  logic [7:0]  b_out_d;
  logic        b_out_v;
  // Instance C: 32/16, 1 stage
  logic [31:0] c_in_d = '0;
  logic        c_in_v = 1'b0;
  logic [5:0]  c_sh_d = '0;
  logic        c_sh_v = 1'b0;
  logic [15:0] c_out_d;
  logic        c_out_v;

  exp_t        q [3][$];
  logic [31:0] last_d [3];
  bit          clr_q [3];
  int          checks = 0;
  int          failures = 0;

  logic [31:0] exp_a [8];

  cic_comb_variable #(.DATA_WIDTH_INP(32), .DATA_WIDTH_OUT(32), .STAGES(3), .DIFF_DELAY(1),
                      .DATA_WIDTH_SHIFT(6)) u_a (
    .clk(clk), .reset(reset),
    .s_axis_in_tdata(a_in_d), .s_axis_in_tvalid(a_in_v),
    .s_axis_shift_tdata(a_sh_d), .s_axis_shift_tvalid(a_sh_v),
    .m_axis_out_tdata(a_out_d), .m_axis_out_tvalid(a_out_v));

  cic_comb_variable #(.DATA_WIDTH_INP(8), .DATA_WIDTH_OUT(8), .STAGES(1), .DIFF_DELAY(1),
                      .DATA_WIDTH_SHIFT(6)) u_b (
    .clk(clk), .reset(reset),
    .s_axis_in_tdata(b_in_d), .s_axis_in_tvalid(b_in_v),
    .s_axis_shift_tdata(b_sh_d), .s_axis_shift_tvalid(b_sh_v),
    .m_axis_out_tdata(b_out_d), .m_axis_out_tvalid(b_out_v));

  cic_comb_variable #(.DATA_WIDTH_INP(32), .DATA_WIDTH_OUT(16), .STAGES(1), .DIFF_DELAY(1),
                      .DATA_WIDTH_SHIFT(6)) u_c (
    .clk(clk), .reset(reset),
    .s_axis_in_tdata(c_in_d), .s_axis_in_tvalid(c_in_v),
    .s_axis_shift_tdata(c_sh_d), .s_axis_shift_tvalid(c_sh_v),
    .m_axis_out_tdata(c_out_d), .m_axis_out_tvalid(c_out_v));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected arrival: input sampled at the next edge, output visible lat edges later.
  task automatic push(input int i, input logic [31:0] d, input int lat);
    exp_t e;
    e.data = d;
    e.cyc  = cyc + lat;
    q[i].push_back(e);
  endtask

  task automatic mon(input int i, input logic v, input logic [31:0] d, input bit clr);
    exp_t e;
    if (clr_q[i]) begin
      checks++;
      if (v !== 1'b0 || d !== 32'd0) begin
        failures++;
        $display("FAIL post_clear[%0d] valid=%b data=%h, required valid=0 data=0", i, v, d);
      end
    end
    if (v === 1'b1) begin
      checks++;
      if (q[i].size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse[%0d] data=%h cyc=%0d, required no pulse", i, d, cyc);
      end else begin
        e = q[i].pop_front();
        if (d !== e.data || cyc != e.cyc) begin
          failures++;
          $display("FAIL out[%0d] data=%h cyc=%0d, required data=%h cyc=%0d",
                   i, d, cyc, e.data, e.cyc);
        end
      end
      last_d[i] = d;
    end else begin
      checks++;
      if (v !== 1'b0 || d !== last_d[i]) begin
        failures++;
        $display("FAIL hold[%0d] valid=%b data=%h, required valid=0 data=%h",
                 i, v, d, last_d[i]);
      end
    end
    if (clr) last_d[i] = 32'd0;
    clr_q[i] = clr;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      last_d[i] = 32'd0;
      clr_q[i]  = 1'b0;
    end
  end

  // Monitor: compares every output cycle against the scoreboard, then drains and summarises.
  always @(negedge clk) begin
    if (done) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (q[i].size() != 0) begin
          failures++;
          $display("FAIL drain[%0d] pending=%0d, required 0", i, q[i].size());
        end
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end else if (cyc > 0) begin
      mon(0, a_out_v, a_out_d, reset | a_sh_v);
      mon(1, b_out_v, {24'd0, b_out_d}, reset | b_sh_v);
      mon(2, c_out_v, {16'd0, c_out_d}, reset | c_sh_v);
    end
  end

  initial begin
    exp_a[0] = 32'd5;
    exp_a[1] = 32'hFFFF_FFF6;
    exp_a[2] = 32'd5;
    for (int k = 3; k < 8; k++) exp_a[k] = 32'd0;

    repeat (3) tick();
    reset = 1'b0;
    tick();

    // A: constant 5 every cycle
    for (int k = 0; k < 8; k++) begin
      a_in_v = 1'b1; a_in_d = 32'd5; push(0, exp_a[k], 4); tick();
    end
    a_in_v = 1'b0;
    repeat (6) tick();
    a_sh_v = 1'b1; a_sh_d = 6'd0; tick();
    a_sh_v = 1'b0;

    // A: constant 5 every third cycle
    for (int k = 0; k < 6; k++) begin
      a_in_v = 1'b1; a_in_d = 32'd5; push(0, exp_a[k], 4); tick();
      a_in_v = 1'b0; tick(); tick();
    end
    repeat (4) tick();

    // B: modular wrap, no saturation
    b_in_v = 1'b1;
    b_in_d = 8'h7F; push(1, 32'h7F, 2); tick();
    b_in_d = 8'h80; push(1, 32'h01, 2); tick();
    b_in_d = 8'h80; push(1, 32'h00, 2); tick();
    b_in_d = 8'h01; push(1, 32'h81, 2); tick();
    b_in_v = 1'b0;
    repeat (3) tick();

    // C: shift 20 clamps to 16, arithmetic shift of negative result
    c_sh_v = 1'b1; c_sh_d = 6'd20; tick();
    c_sh_v = 1'b0;
    c_in_v = 1'b1;
    c_in_d = 32'h0005_0000; push(2, 32'h0005, 2); tick();
    c_in_d = 32'h0005_0000; push(2, 32'h0000, 2); tick();
    c_in_d = 32'hFFFB_0000; push(2, 32'hFFF6, 2); tick();
    c_in_v = 1'b0;
    repeat (3) tick();

    // A: flush with two samples in flight plus a simultaneous input
    a_in_v = 1'b1; a_in_d = 32'd3; tick();
    a_in_d = 32'd4; tick();
    a_in_d = 32'd99; a_sh_v = 1'b1; a_sh_d = 6'd0; tick();
    a_in_v = 1'b0; a_sh_v = 1'b0;
    repeat (6) tick();
    a_in_v = 1'b1;
    a_in_d = 32'd7; push(0, 32'd7, 4); tick();
    a_in_d = 32'd7; push(0, 32'hFFFF_FFF2, 4); tick();
    a_in_v = 1'b0;
    repeat (6) tick();

    // C: reset one cycle after an input drops it and restores shift 16
    c_sh_v = 1'b1; c_sh_d = 6'd0; tick();
    c_sh_v = 1'b0;
    c_in_v = 1'b1; c_in_d = 32'h0005_0000; tick();
    c_in_v = 1'b0; reset = 1'b1; tick();
    reset = 1'b0;
    repeat (5) tick();
    c_in_v = 1'b1; c_in_d = 32'h0005_0000; push(2, 32'h0005, 2); tick();
    c_in_v = 1'b0;

    for (int t = 0; t < 50; t++) begin
      if (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0) break;
      tick();
    end
    tick();
    done = 1'b1;
  end

endmodule

// File: doc/cic_comb_variable.md
CIC_COMB_VARIABLE -- requirements
Module: cic_comb_variable

Interface
REQ-001 SHALL have parameter DATA_WIDTH_INP, default 32, width of comb input and of all internal stage registers.
REQ-002 SHALL have parameter DATA_WIDTH_OUT, default 16, output sample width; SHALL satisfy DATA_WIDTH_OUT <= DATA_WIDTH_INP.
REQ-003 SHALL have parameter STAGES, default 3, number of comb sections (1..8).
REQ-004 SHALL have parameter DIFF_DELAY, default 1, differential delay M per section (1 or 2).
REQ-005 SHALL have parameter DATA_WIDTH_SHIFT, default 6, width of the shift control word.
REQ-006 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port s_axis_in_tdata, input, DATA_WIDTH_INP, signed decimated samples from the upstream downsampler.
REQ-009 SHALL have port s_axis_in_tvalid, input, 1, qualifies s_axis_in_tdata; no backpressure.
REQ-010 SHALL have port s_axis_shift_tdata, input, DATA_WIDTH_SHIFT, unsigned output right-shift amount, set alongside each rate change.
REQ-011 SHALL have port s_axis_shift_tvalid, input, 1, loads the shift and flushes the pipeline.
REQ-012 SHALL have port m_axis_out_tdata, output, DATA_WIDTH_OUT, signed scaled comb output (registered).
REQ-013 SHALL have port m_axis_out_tvalid, output, 1, one-cycle pulse per output sample (registered).

Function
REQ-014 Each section k SHALL compute y_k = x_k - x_k delayed by DIFF_DELAY accepted samples; section 0 input is s_axis_in_tdata.
REQ-015 All comb arithmetic SHALL be two's-complement modulo 2^DATA_WIDTH_INP; wrap-around is intended and SHALL NOT be saturated or flagged.
REQ-016 Each section SHALL be one register stage; its delay line and output register SHALL update only in cycles where that section's input valid is high.
REQ-017 Valid SHALL propagate one section per clock without stalls; idle cycles SHALL hold all delay lines and data unchanged.
REQ-018 A final scaling register SHALL output the DATA_WIDTH_OUT LSBs of (section STAGES-1 result arithmetic-shifted right by shift_reg).
REQ-019 shift_reg values above DATA_WIDTH_INP-DATA_WIDTH_OUT SHALL be clamped to DATA_WIDTH_INP-DATA_WIDTH_OUT.
REQ-020 Latency from s_axis_in_tvalid high at edge t to m_axis_out_tvalid high SHALL be exactly STAGES+1 clocks; one output per input, order preserved.
REQ-021 Back-to-back input valids every cycle SHALL be supported at full throughput.
REQ-022 s_axis_shift_tvalid high SHALL, on the next edge, load shift_reg, clear all delay lines, stage registers, in-flight valids, m_axis_out_tdata and m_axis_out_tvalid.
REQ-023 If s_axis_shift_tvalid and s_axis_in_tvalid are high in the same cycle, the shift load/flush SHALL win and the input sample SHALL be discarded.
REQ-024 m_axis_out_tdata SHALL hold its last value between valid pulses.

Reset
REQ-025 reset high at a clock edge SHALL clear all delay lines, stage registers and in-flight valids, set m_axis_out_tdata = 0, m_axis_out_tvalid = 0, shift_reg = DATA_WIDTH_INP-DATA_WIDTH_OUT.
REQ-026 reset SHALL take precedence over s_axis_shift_tvalid and s_axis_in_tvalid; reset asserted mid-stream SHALL drop all in-flight samples (no output pulse afterwards until new input).

Verification
REQ-027 STAGES=3, M=1, DATA_WIDTH_OUT=DATA_WIDTH_INP=32, shift 0, constant input 5 every cycle -> outputs 5, -10, 5, 0, 0... starting 4 clocks after first input valid.
REQ-028 Same config, input valid every 3rd cycle with value 5 -> identical output sequence, each pulse 4 clocks after its input, m_axis_out_tdata held between pulses.
REQ-029 Wrap: DATA_WIDTH_INP=8, OUT=8, STAGES=1, shift 0, inputs 127 then -128 -> outputs 127 then 1 (modular), no saturation.
REQ-030 Scaling: defaults, shift loaded 20 (clamps to 16), STAGES=1, input 0x00050000 -> output 5.
REQ-031 Shift load with 2 samples in flight and simultaneous input valid -> no output pulses from those 3 samples, next input treated as first sample (delay lines zero).
REQ-032 Reset asserted one cycle after an input valid -> m_axis_out_tvalid stays 0, shift_reg returns to 16, outputs 0.
